uart_key_rx: RTL and testbench
==============================

UART_KEY_RX -- requirements
Module: uart_key_rx

Interface
REQ-001 Parameter CLOCK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; even, >= 8.
REQ-004 clock  input  1  single system clock; all logic on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  1  asynchronous serial line (8N1, LSB first); idles high.
REQ-007 received  output  1  one-cycle pulse: a valid byte is on received_data.
REQ-008 received_data  output  8  last correctly framed byte; held until the next valid byte.
REQ-009 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-011 `in` SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1; all decisions SHALL use the synchronized value only.
REQ-012 Tick divider DIV = CLOCK_HZ/(BAUD*OVERSAMPLE), integer-truncated (325 at defaults); a one-cycle tick SHALL fire every DIV clocks.
REQ-013 The divider SHALL restart from 0 on IDLE->START so that tick phase aligns to the detected falling edge.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: a synchronized low SHALL move to START; busy=0.
REQ-016 START: the bit value SHALL be a majority vote of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Vote 1 (false start) -> IDLE, with no output. Vote 0 -> DATA, with the tick count re-based so later samples fall mid-bit.
REQ-017 DATA: 8 bits, each majority-voted at the same mid-bit ticks, one bit per OVERSAMPLE ticks; shifted in LSB first into an internal shift register; a 3-bit index SHALL count 0..7, and the transition to STOP SHALL occur after index 7.
REQ-018 STOP: stop bit majority-voted mid-bit.
  - 1: received SHALL pulse for exactly one clock, received_data SHALL load the shift register in that same cycle, next state IDLE.
  - 0: frame_error SHALL pulse for one clock, received_data unchanged, next state BREAK.
REQ-019 BREAK: remain until synchronized `in` is high for one full bit time (OVERSAMPLE consecutive high ticks), then IDLE.
REQ-020 Latency: the received pulse SHALL occur no later than 2 (sync) + 1 clocks after the tick on which the stop-bit vote completes, about 9.5 bit times after the start edge.
REQ-021 received and frame_error SHALL never be asserted in the same cycle.
REQ-022 Back-to-back frames: a start edge detected in the first cycle after STOP->IDLE SHALL be accepted; no idle gap is required beyond the stop bit's second half.
REQ-023 The line held low continuously SHALL yield at most one frame_error and no received pulse until the line returns high.
REQ-024 Tick and bit counters SHALL be sized by $clog2 of their maxima; no counter SHALL wrap within a frame.

Reset
REQ-025 Reset SHALL force state IDLE, all counters to 0, synchronizer flops to 1, received=0, frame_error=0, busy=0, received_data=8'h00.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse output; reception SHALL resume with the first falling edge after reset deasserts.

Structure
REQ-027 A shared package SHALL hold CLOCK_HZ, BAUD, OVERSAMPLE defaults and the key-code constants KEY_SPACE=32, KEY_W=119, KEY_S=115, KEY_P=112, KEY_L=108, for use by the game controller.
REQ-028 The tick divider SHALL be one sub-module, baud_tick_gen (inputs clock, reset, restart; output tick).
REQ-029 The output pulse SHALL be directly compatible with the existing single-pulse edge stage (level-high for exactly one cycle).

Verification
REQ-030 Frame 0x20 at 9600 baud, 50 MHz -> exactly one received pulse, received_data=0x20, frame_error never high, busy falls after the stop bit.
REQ-031 Frames 0x77, 0x73, 0x70, 0x6C sent back-to-back with no idle gap -> four pulses, in order, with matching data.
REQ-032 Low glitch of 3 ticks on an idle line -> no received pulse, no frame_error, busy back to 0 within 1 bit time.
REQ-033 Frame 0x55 with stop bit forced low, then line held low 3 bit times, then high -> one frame_error pulse, received_data keeps its previous value (0x20), next valid 0x41 is received correctly.
REQ-034 Reset asserted at data bit 4 of frame 0x77 -> no pulse, received_data=0x00, busy=0; next frame 0x73 -> received_data=0x73.
REQ-035 Single-tick noise spike inverting one sample of data bit 2 in frame 0x70 -> majority vote masks it; received_data=0x70.

Source files
------------

// File: rtl/uart_key_rx_pkg.sv
// Shared definitions for the keyboard UART receiver and the game controller
// that consumes its key codes.
package uart_key_rx_pkg;

  localparam int DEF_CLOCK_HZ   = 50_000_000;
  localparam int DEF_BAUD       = 9600;
  localparam int DEF_OVERSAMPLE = 16;

  localparam logic [7:0] KEY_SPACE = 8'd32;
  localparam logic [7:0] KEY_W     = 8'd119;
  localparam logic [7:0] KEY_S     = 8'd115;
  localparam logic [7:0] KEY_P     = 8'd112;
  localparam logic [7:0] KEY_L     = 8'd108;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Two-out-of-three vote used to reject single-sample noise.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_key_rx_baud_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks. Restart realigns
// the tick phase to the clock edge on which it is asserted.
module baud_tick_gen
  import uart_key_rx_pkg::*;
#(
  parameter int DIV = DEF_CLOCK_HZ / (DEF_BAUD * DEF_OVERSAMPLE)
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int              DIV_SAFE = (DIV > 1) ? DIV : 2;
  localparam int              CW       = $clog2(DIV_SAFE);
  localparam logic [CW-1:0]   LAST     = CW'(DIV_SAFE - 1);

  logic [CW-1:0] count;

  // Count 0..DIV-1 and emit a registered tick when the count rolls over.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_key_rx.sv
// 8N1 UART receiver for keyboard key codes, with 3-sample majority voting
// at mid-bit and a break state that waits out a held-low line.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a synchronized low
// ST_START | validating the start bit by mid-bit vote
// ST_DATA  | shifting in 8 data bits, LSB first
// ST_STOP  | voting the stop bit; emits received or frame_error
// ST_BREAK | line stuck low after a bad stop; wait one full high bit
module uart_key_rx
  import uart_key_rx_pkg::*;
#(
  parameter int CLOCK_HZ   = DEF_CLOCK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in,
  output logic       received,
  output logic [7:0] received_data,
  output logic       frame_error,
  output logic       busy
);

  localparam int            DIV    = CLOCK_HZ / (BAUD * OVERSAMPLE);
  localparam int            HALF   = OVERSAMPLE / 2;
  localparam int            TW     = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] S_EARLY = TW'(HALF - 1);
  localparam logic [TW-1:0] S_MID   = TW'(HALF);
  localparam logic [TW-1:0] S_LATE  = TW'(HALF + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);

  logic          sync_0;
  logic          sync_1;
  rx_state_t     state;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] high_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          s_early;
  logic          s_mid;
  logic          tick;
  logic          restart;
  logic          vote;

  // Start-edge detection restarts the divider so ticks line up with the edge.
  assign restart = (state == ST_IDLE) && !sync_1;
  assign vote    = maj3(s_early, s_mid, sync_1);

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0 <= 1'b1;
      sync_1 <= 1'b1;
    end else begin
      sync_0 <= in;
      sync_1 <= sync_0;
    end
  end

  // Receive FSM with registered pulse outputs and busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      high_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      s_early       <= 1'b0;
      s_mid         <= 1'b0;
      received      <= 1'b0;
      received_data <= 8'h00;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      received    <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
          if (!sync_1) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START, ST_DATA, ST_STOP: begin
          if (tick) begin
            // tick_cnt is the phase within the current bit; it rolls over at
            // each bit boundary so every bit is sampled at the same mid-bit ticks.
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == S_EARLY) s_early <= sync_1;
            if (tick_cnt == S_MID)   s_mid   <= sync_1;
            if (tick_cnt == S_LATE) begin
              if (state == ST_START) begin
                if (vote) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= ST_DATA;
                end
              end else if (state == ST_DATA) begin
                shift <= {vote, shift[7:1]};
                if (bit_idx == 3'd7) state <= ST_STOP;
                else                 bit_idx <= bit_idx + 1'b1;
              end else begin
                if (vote) begin
                  received      <= 1'b1;
                  received_data <= shift;
                  state         <= ST_IDLE;
                  busy          <= 1'b0;
                end else begin
                  frame_error <= 1'b1;
                  high_cnt    <= '0;
                  state       <= ST_BREAK;
                end
              end
            end
          end
        end
        ST_BREAK: begin
          if (tick) begin
            if (!sync_1) begin
              high_cnt <= '0;
            end else if (high_cnt == T_LAST) begin
              high_cnt <= '0;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              high_cnt <= high_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_key_rx.sv
// Bench for uart_key_rx: bit-timed serial stimulus against a byte-level
// expectation model (queue of bytes that should arrive, count of framing errors).
module tb_uart_key_rx;
  import uart_key_rx_pkg::*;

  localparam int CLK_HZ  = 614400;
  localparam int BAUD    = 9600;
  localparam int OS      = 16;
  localparam int DIV     = CLK_HZ / (BAUD * OS);
  localparam int BIT     = DIV * OS;
  // Window of one tick around the middle vote sample, narrower than the
  // spacing between samples so it can corrupt only one of the three.
  localparam int SPIKE_LO = (OS / 2 + 1) * DIV;
  localparam int SPIKE_HI = (OS / 2 + 1) * DIV + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in    = 1'b1;
  logic       received;
  logic [7:0] received_data;
  logic       frame_error;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int last_rx_cyc = 0;
  int frame_start_cyc = 0;
  logic mid_busy = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_key_rx #(.CLOCK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clock         (clock),
    .reset         (reset),
    .in            (in),
    .received      (received),
    .received_data (received_data),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (received) begin
      rx_q.push_back(received_data);
      last_rx_cyc = cyc;
    end
    if (frame_error) fe_cnt++;
    if (received && frame_error) both_cnt++;
  end

  task automatic idle(input int n);
    in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int spike_bit, input int abort_bit);
    logic v;
    for (int fb = 0; fb < 10; fb++) begin
      if (fb == 0)      v = 1'b0;
      else if (fb == 9) v = stop_val;
      else              v = b[fb-1];
      for (int k = 0; k < BIT; k++) begin
        if (abort_bit >= 0 && fb == abort_bit + 1 && k == BIT / 2) return;
        @(negedge clock);
        if (fb == 0 && k == 0) frame_start_cyc = cyc;
        if (fb == 5 && k == 0) mid_busy = busy;
        if (spike_bit >= 0 && fb == spike_bit + 1 && k >= SPIKE_LO && k <= SPIKE_HI)
          in = ~v;
        else
          in = v;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in    = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (received !== 1'b0) begin errors++; $display("FAIL reset_received: got %b expected 0", received); end
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (received_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", received_data); end
    reset = 1'b0;
    idle(BIT);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      errors++; $display("FAIL post_reset_idle: busy %b pulses %0d expected 0 0", busy, rx_q.size());
    end
  endtask

  task automatic test_single_frame();
    int delta;
    rx_q.delete(); fe_cnt = 0;
    send_frame(KEY_SPACE, 1'b1, -1, -1);
    idle(BIT);
    last_good = KEY_SPACE;
    checks++;
    if (mid_busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b expected 1", mid_busy); end
    checks++;
    if (rx_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
    else begin
      checks++;
      if (rx_q[0] !== KEY_SPACE) begin errors++; $display("FAIL single_data: got %02h expected %02h", rx_q[0], KEY_SPACE); end
    end
    checks++;
    if (fe_cnt != 0) begin errors++; $display("FAIL single_frame_error: got %0d expected 0", fe_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    delta = last_rx_cyc - frame_start_cyc;
    checks++;
    if (delta < 9 * BIT + BIT / 4 || delta > 9 * BIT + 3 * BIT / 4) begin
      errors++; $display("FAIL single_latency: got %0d cycles expected %0d..%0d", delta, 9 * BIT + BIT / 4, 9 * BIT + 3 * BIT / 4);
    end
  endtask

  task automatic test_glitch();
    int waited;
    rx_q.delete(); fe_cnt = 0;
    in = 1'b0;
    repeat (3 * DIV) @(negedge clock);
    in = 1'b1;
    waited = 0;
    while (busy && waited < BIT) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b after %0d cycles expected 0", busy, waited); end
    idle(2 * BIT);
    checks++;
    if (rx_q.size() != 0 || fe_cnt != 0) begin
      errors++; $display("FAIL glitch_outputs: pulses %0d frame_errors %0d expected 0 0", rx_q.size(), fe_cnt);
    end
  endtask

  task automatic test_frame_error();
    rx_q.delete(); fe_cnt = 0;
    send_frame(8'h55, 1'b0, -1, -1);
    in = 1'b0;
    repeat (3 * BIT) @(negedge clock);
    idle(2 * BIT);
    checks++;
    if (fe_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt); end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL ferr_pulses: got %0d expected 0", rx_q.size()); end
    checks++;
    if (received_data !== last_good) begin errors++; $display("FAIL ferr_data_held: got %02h expected %02h", received_data, last_good); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", busy); end
    send_frame(8'h41, 1'b1, -1, -1);
    idle(BIT);
    last_good = 8'h41;
    checks++;
    if (rx_q.size() != 1 || received_data !== 8'h41) begin
      errors++; $display("FAIL ferr_recover: pulses %0d data %02h expected 1 41", rx_q.size(), received_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] keys[4];
    keys[0] = KEY_W; keys[1] = KEY_S; keys[2] = KEY_P; keys[3] = KEY_L;
    rx_q.delete(); fe_cnt = 0;
    for (int i = 0; i < 4; i++) send_frame(keys[i], 1'b1, -1, -1);
    idle(BIT);
    last_good = KEY_L;
    checks++;
    if (rx_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== keys[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %02h expected %02h", i, rx_q[i], keys[i]); end
    end
    checks++;
    if (fe_cnt != 0) begin errors++; $display("FAIL b2b_frame_error: got %0d expected 0", fe_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    rx_q.delete(); fe_cnt = 0;
    send_frame(KEY_W, 1'b1, -1, 4);
    reset = 1'b1;
    in    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(2 * BIT);
    last_good = 8'h00;
    checks++;
    if (rx_q.size() != 0 || fe_cnt != 0) begin
      errors++; $display("FAIL rstmid_pulses: pulses %0d frame_errors %0d expected 0 0", rx_q.size(), fe_cnt);
    end
    checks++;
    if (received_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %02h expected 00", received_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    send_frame(KEY_S, 1'b1, -1, -1);
    idle(BIT);
    last_good = KEY_S;
    checks++;
    if (rx_q.size() != 1 || received_data !== KEY_S) begin
      errors++; $display("FAIL rstmid_next: pulses %0d data %02h expected 1 73", rx_q.size(), received_data);
    end
  endtask

  task automatic test_noise_spike();
    rx_q.delete(); fe_cnt = 0;
    send_frame(KEY_P, 1'b1, 2, -1);
    idle(BIT);
    last_good = KEY_P;
    checks++;
    if (rx_q.size() != 1 || received_data !== KEY_P) begin
      errors++; $display("FAIL noise_vote: pulses %0d data %02h expected 1 70", rx_q.size(), received_data);
    end
  endtask

  task automatic test_random();
    int exp_fe;
    logic [7:0] b;
    logic bad;
    rx_q.delete(); exp_q.delete(); fe_cnt = 0; exp_fe = 0;
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, -1, -1);
      if (bad) begin
        exp_fe++;
        idle(2 * BIT);
      end else begin
        exp_q.push_back(b);
        last_good = b;
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, BIT));
      end
    end
    idle(2 * BIT);
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (fe_cnt != exp_fe) begin errors++; $display("FAIL rand_frame_errors: got %0d expected %0d", fe_cnt, exp_fe); end
    checks++;
    if (received_data !== last_good) begin errors++; $display("FAIL rand_last_data: got %02h expected %02h", received_data, last_good); end
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL pulse_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_noise_spike();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
